// File: rtl/rv_spsram_arb.sv
// Arbitrates instruction fetch and load/store onto one single-port SRAM.
// Grant -> registered command -> SRAM access -> registered read data to the owning port.
module rv_spsram_arb #(
    parameter int BW_DATA  = 32,
    parameter int BW_ADDR  = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic               i_sparb_clk,
    input  logic               i_sparb_rst,
    input  logic               i_sparb_if_req,
    input  logic [BW_ADDR-1:0] i_sparb_if_addr,
    output logic               o_sparb_if_gnt,
    output logic               o_sparb_if_rvalid,
    output logic [BW_DATA-1:0] o_sparb_if_rdata,
    input  logic               i_sparb_ls_req,
    input  logic               i_sparb_ls_wen,
    input  logic [BW_ADDR-1:0] i_sparb_ls_addr,
    input  logic [BW_DATA-1:0] i_sparb_ls_wdata,
    output logic               o_sparb_ls_gnt,
    output logic               o_sparb_ls_rvalid,
    output logic [BW_DATA-1:0] o_sparb_ls_rdata,
    output logic               o_sparb_mem_cen,
    output logic               o_sparb_mem_wen,
    output logic               o_sparb_mem_ren,
    output logic [BW_ADDR-1:0] o_sparb_mem_addr,
    output logic [BW_DATA-1:0] o_sparb_mem_data,
    input  logic [BW_DATA-1:0] i_sparb_mem_rdata
);
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] MAXW = SW'(MAX_WAIT);

    logic               r_cmd_vld;
    logic               r_cmd_src;   // 1 = LS, 0 = IF
    logic               r_cmd_wen;
    logic [BW_ADDR-1:0] r_cmd_addr;
    logic [BW_DATA-1:0] r_cmd_data;
    logic               r_if_rvalid;
    logic               r_ls_rvalid;
    logic [BW_DATA-1:0] r_if_rdata;
    logic [BW_DATA-1:0] r_ls_rdata;
    logic [SW-1:0]      r_starve_cnt;

    logic w_starved;
    logic w_if_gnt;
    logic w_ls_gnt;
    logic w_ren;

    // LS has priority unless IF has waited MAX_WAIT cycles in a row.
    assign w_starved = (r_starve_cnt == MAXW);
    assign w_if_gnt  = !i_sparb_rst && i_sparb_if_req && (!i_sparb_ls_req || w_starved);
    assign w_ls_gnt  = !i_sparb_rst && i_sparb_ls_req && !(i_sparb_if_req && w_starved);

    always_ff @(posedge i_sparb_clk or posedge i_sparb_rst) begin
        if (i_sparb_rst) begin
            r_starve_cnt <= '0;
        end else if (i_sparb_if_req && !w_if_gnt) begin
            if (!w_starved)
                r_starve_cnt <= r_starve_cnt + SW'(1);
        end else begin
            r_starve_cnt <= '0;
        end
    end

    always_ff @(posedge i_sparb_clk or posedge i_sparb_rst) begin
        if (i_sparb_rst) begin
            r_cmd_vld  <= 1'b0;
            r_cmd_src  <= 1'b0;
            r_cmd_wen  <= 1'b0;
            r_cmd_addr <= '0;
            r_cmd_data <= '0;
        end else begin
            r_cmd_vld  <= w_if_gnt || w_ls_gnt;
            r_cmd_src  <= w_ls_gnt;
            r_cmd_wen  <= w_ls_gnt && i_sparb_ls_wen;
            r_cmd_addr <= w_ls_gnt ? i_sparb_ls_addr :
                          w_if_gnt ? i_sparb_if_addr : '0;
            r_cmd_data <= w_ls_gnt ? i_sparb_ls_wdata : '0;
        end
    end

    assign w_ren = r_cmd_vld && !r_cmd_wen;

    always_ff @(posedge i_sparb_clk or posedge i_sparb_rst) begin
        if (i_sparb_rst) begin
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_if_rvalid <= w_ren && !r_cmd_src;
            r_ls_rvalid <= w_ren && r_cmd_src;
            if (w_ren && !r_cmd_src) r_if_rdata <= i_sparb_mem_rdata;
            if (w_ren && r_cmd_src)  r_ls_rdata <= i_sparb_mem_rdata;
        end
    end

    assign o_sparb_if_gnt    = w_if_gnt;
    assign o_sparb_ls_gnt    = w_ls_gnt;
    assign o_sparb_if_rvalid = r_if_rvalid;
    assign o_sparb_ls_rvalid = r_ls_rvalid;
    assign o_sparb_if_rdata  = r_if_rdata;
    assign o_sparb_ls_rdata  = r_ls_rdata;

    assign o_sparb_mem_cen  = r_cmd_vld;
    assign o_sparb_mem_wen  = r_cmd_vld && r_cmd_wen;
    assign o_sparb_mem_ren  = w_ren;
    assign o_sparb_mem_addr = r_cmd_vld ? r_cmd_addr : '0;
    assign o_sparb_mem_data = r_cmd_vld ? r_cmd_data : '0;

endmodule

// File: tb/tb_rv_spsram_arb.sv
// Directed bench for rv_spsram_arb with a behavioural single-port SRAM attached.
module tb_rv_spsram_arb;
    localparam int BW_DATA  = 32;
    localparam int BW_ADDR  = 4;
    localparam int MAX_WAIT = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               if_req = 1'b0;
    logic [BW_ADDR-1:0] if_addr = '0;
    logic               if_gnt, if_rvalid, ls_gnt, ls_rvalid;
    logic [BW_DATA-1:0] if_rdata, ls_rdata;
    logic               ls_req = 1'b0, ls_wen = 1'b0;
    logic [BW_ADDR-1:0] ls_addr = '0;
    logic [BW_DATA-1:0] ls_wdata = '0;
    logic               mem_cen, mem_wen, mem_ren;
    logic [BW_ADDR-1:0] mem_addr;
    logic [BW_DATA-1:0] mem_data, mem_rdata;

    logic [BW_DATA-1:0] sram [16];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rv_spsram_arb #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR), .MAX_WAIT(MAX_WAIT)) dut (
        .i_sparb_clk(clk), .i_sparb_rst(rst),
        .i_sparb_if_req(if_req), .i_sparb_if_addr(if_addr),
        .o_sparb_if_gnt(if_gnt), .o_sparb_if_rvalid(if_rvalid), .o_sparb_if_rdata(if_rdata),
        .i_sparb_ls_req(ls_req), .i_sparb_ls_wen(ls_wen), .i_sparb_ls_addr(ls_addr),
        .i_sparb_ls_wdata(ls_wdata),
        .o_sparb_ls_gnt(ls_gnt), .o_sparb_ls_rvalid(ls_rvalid), .o_sparb_ls_rdata(ls_rdata),
        .o_sparb_mem_cen(mem_cen), .o_sparb_mem_wen(mem_wen), .o_sparb_mem_ren(mem_ren),
        .o_sparb_mem_addr(mem_addr), .o_sparb_mem_data(mem_data),
        .i_sparb_mem_rdata(mem_rdata)
    );

    // SRAM macro: combinational read, write on the rising edge.
    assign mem_rdata = sram[mem_addr];
    always @(posedge clk) if (mem_cen && mem_wen) sram[mem_addr] <= mem_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        if_req = 1'b0;
        ls_req = 1'b0;
        ls_wen = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) sram[i] = '0;
        sram[1] = 32'h1111_1111;
        sram[2] = 32'h2222_2222;
        sram[5] = 32'h0000_0013;

        // Grants held low while reset is high, even with requests present.
        if_req = 1'b1;
        ls_req = 1'b1;
        #2;
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
        chk("rst_cen", 32'(mem_cen), 32'd0);
        idle_reqs();
        nxt();
        nxt();
        rst = 1'b0;

        // Idle: nothing moves for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            nxt();
            #1;
            chk("idle_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
            chk("idle_rv", 32'({if_rvalid, ls_rvalid}), 32'd0);
            chk("idle_cen", 32'(mem_cen), 32'd0);
            chk("idle_starve", 32'(dut.r_starve_cnt), 32'd0);
        end

        // LS write 3 <- DEADBEEF, then LS read 3 right behind it.
        nxt();
        ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 4'd3; ls_wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_gnt", 32'(ls_gnt), 32'd1);
        nxt();
        ls_wen = 1'b0; ls_wdata = '0;
        #1;
        chk("wr_mem_wen", 32'(mem_wen), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'd3);
        chk("wr_mem_data", mem_data, 32'hDEAD_BEEF);
        chk("rd_gnt", 32'(ls_gnt), 32'd1);
        nxt();
        idle_reqs();
        #1;
        chk("wr_no_rvalid", 32'(ls_rvalid), 32'd0);
        chk("rd_mem_ren", 32'(mem_ren), 32'd1);
        nxt();
        #1;
        chk("rd_rvalid", 32'(ls_rvalid), 32'd1);
        chk("rd_rdata", ls_rdata, 32'hDEAD_BEEF);
        nxt();
        #1;
        chk("rd_pulse_end", 32'(ls_rvalid), 32'd0);
        chk("rd_hold", ls_rdata, 32'hDEAD_BEEF);

        // IF-only read of addr 5.
        if_req = 1'b1; if_addr = 4'd5;
        #1;
        chk("if_gnt", 32'({if_gnt, ls_gnt}), 32'b10);
        nxt();
        idle_reqs();
        #1;
        chk("if_mem_ren", 32'(mem_ren), 32'd1);
        chk("if_mem_addr", 32'(mem_addr), 32'd5);
        nxt();
        #1;
        chk("if_rvalid", 32'({if_rvalid, ls_rvalid}), 32'b10);
        chk("if_rdata", if_rdata, 32'h0000_0013);

        // Both requesting: LS wins four times, then IF is forced through.
        nxt();
        if_req = 1'b1; if_addr = 4'd1;
        ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 4'd2;
        for (int k = 0; k < 15; k++) begin
            #1;
            chk("fair_if_gnt", 32'(if_gnt), 32'((k % 5) == 4));
            chk("fair_ls_gnt", 32'(ls_gnt), 32'((k % 5) != 4));
            chk("fair_rv_excl", 32'(if_rvalid && ls_rvalid), 32'd0);
            nxt();
        end
        idle_reqs();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fair_rv_excl", 32'(if_rvalid && ls_rvalid), 32'd0);
            nxt();
        end

        // Async reset with an LS read in flight.
        ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 4'd2;
        #1;
        chk("ar_gnt", 32'(ls_gnt), 32'd1);
        nxt();
        idle_reqs();
        #1;
        chk("ar_cen_pre", 32'(mem_cen), 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_cen_drop", 32'(mem_cen), 32'd0);
        nxt();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ar_no_rvalid", 32'(ls_rvalid), 32'd0);
            nxt();
        end
        if_req = 1'b1; if_addr = 4'd5;
        #1;
        chk("ar_post_gnt", 32'(if_gnt), 32'd1);
        nxt();
        idle_reqs();
        nxt();
        #1;
        chk("ar_post_rvalid", 32'(if_rvalid), 32'd1);
        chk("ar_post_rdata", if_rdata, 32'h0000_0013);

        // Alternating single requests: IF 1, LS 2, IF 3.
        nxt();
        if_req = 1'b1; if_addr = 4'd1;
        nxt();
        if_req = 1'b0; ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 4'd2;
        nxt();
        ls_req = 1'b0; if_req = 1'b1; if_addr = 4'd3;
        #1;
        chk("alt_rv0", 32'({if_rvalid, ls_rvalid}), 32'b10);
        chk("alt_d0", if_rdata, 32'h1111_1111);
        nxt();
        idle_reqs();
        #1;
        chk("alt_rv1", 32'({if_rvalid, ls_rvalid}), 32'b01);
        chk("alt_d1", ls_rdata, 32'h2222_2222);
        nxt();
        #1;
        chk("alt_rv2", 32'({if_rvalid, ls_rvalid}), 32'b10);
        chk("alt_d2", if_rdata, 32'hDEAD_BEEF);
        nxt();
        #1;
        chk("alt_quiet", 32'({if_rvalid, ls_rvalid}), 32'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_spsram_arb.md
Name: rv_spsram_arb

Overview:
- Two-port arbiter and sequencer that shares one single-port SRAM between instruction fetch (IF, read-only) and load/store (LS, read/write).
- Each cycle it grants at most one requester and registers the command.
- It drives the SRAM control pins one cycle later and returns registered read data to the owning port.
- It sits between the fetch/LSU stages and the single-port SRAM macro, which has a combinational read and a synchronous write.

Parameters:
BW_DATA, 32, data width of SRAM word and all data ports
BW_ADDR, 4, SRAM word-address width
MAX_WAIT, 4, max consecutive cycles IF may be denied while requesting before it is force-granted; legal range >= 1

Ports:
i_sparb_clk  in  1  clock; all state on rising edge
i_sparb_rst  in  1  asynchronous, active-high reset
i_sparb_if_req  in  1  IF read request; held with addr until granted
i_sparb_if_addr  in  BW_ADDR  IF read address
o_sparb_if_gnt  out  1  IF request accepted this cycle (combinational)
o_sparb_if_rvalid  out  1  one-cycle pulse, IF read data valid
o_sparb_if_rdata  out  BW_DATA  IF read data
i_sparb_ls_req  in  1  LS request; held with wen/addr/wdata until granted
i_sparb_ls_wen  in  1  1 = write, 0 = read
i_sparb_ls_addr  in  BW_ADDR  LS address
i_sparb_ls_wdata  in  BW_DATA  LS write data
o_sparb_ls_gnt  out  1  LS request accepted this cycle (combinational)
o_sparb_ls_rvalid  out  1  one-cycle pulse, LS read data valid (reads only)
o_sparb_ls_rdata  out  BW_DATA  LS read data
o_sparb_mem_cen  out  1  SRAM chip enable
o_sparb_mem_wen  out  1  SRAM write enable
o_sparb_mem_ren  out  1  SRAM read enable
o_sparb_mem_addr  out  BW_ADDR  SRAM address
o_sparb_mem_data  out  BW_DATA  SRAM write data
i_sparb_mem_rdata  in  BW_DATA  SRAM combinational read data

Behaviour:
- Reset is asynchronous and active-high.
  - Clears cmd_vld, cmd_src, cmd_wen, cmd_addr, cmd_data, both rvalid flags, both rdata registers, and starve_cnt to 0.
  - In-flight commands are dropped.
  - While reset is high, both gnt outputs are forced to 0 and all o_sparb_mem_* outputs are 0.
- Handshake: a transfer occurs in a cycle with req && gnt. gnt depends only on the reqs and starve_cnt. There is no backpressure, so if any req is high, exactly one gnt is high.
- Arbitration:
  - Only one req high: that requester is granted.
  - Both high: LS wins, unless starve_cnt == MAX_WAIT, in which case IF wins.
- starve_cnt, width $clog2(MAX_WAIT+1):
  - Increments (saturating at MAX_WAIT) when if_req && !if_gnt.
  - Clears to 0 when if_gnt or !if_req.
- Stage 1 (command register), on each edge:
  - cmd_vld <= any grant.
  - cmd_src <= LS granted.
  - cmd_wen <= LS granted && ls_wen.
  - cmd_addr and cmd_data are loaded from the granted port.
  - IF commands load cmd_data = 0.
- SRAM drive, combinational from the command register:
  - cen = cmd_vld.
  - wen = cmd_vld && cmd_wen.
  - ren = cmd_vld && !cmd_wen.
  - addr and data come from the command register; all are 0 when !cmd_vld.
- Stage 2 (response): when ren is high, capture i_sparb_mem_rdata into the rdata register of the port given by cmd_src, and set that port's rvalid for exactly one cycle.
- rdata registers hold their last value between pulses.
- Latency:
  - Grant in cycle N → SRAM access in N+1 → rvalid/rdata in N+2.
  - A write commits at the end of N+1 and produces no rvalid.
- Throughput is one command per cycle; the pipeline never stalls.
- Ordering:
  - Commands reach the SRAM in grant order.
  - An LS write granted in N followed by any read of the same address granted in N+1 returns the new data.
- Both ports may receive rvalid in consecutive cycles but never in the same cycle.

Test Plan:
- Reset then idle, no reqs → all gnt/rvalid/mem_cen = 0 for 10 cycles; starve_cnt = 0.
- LS write addr 3 data 0xDEADBEEF at cycle N, LS read addr 3 at N+1 → mem_wen=1 at N+1; ls_rvalid=1 with rdata 0xDEADBEEF at N+3; no rvalid at N+2.
- IF read addr 5 only (preloaded 0x00000013) → if_gnt same cycle, mem_ren at N+1, if_rvalid with 0x00000013 at N+2.
- Both req continuously, MAX_WAIT=4 → LS granted 4 cycles, IF granted on 5th, pattern repeats; if_rvalid never coincides with ls_rvalid.
- Async reset asserted mid-cycle with cmd_vld=1 (LS read in flight) → mem_cen drops immediately; no ls_rvalid after reset release; first post-reset grant behaves normally.
- Back-to-back alternating single reqs IF addr 1, LS read addr 2, IF addr 3 → rvalids at consecutive cycles on IF, LS, IF with correct data.
